uart_tx_parity: RTL and testbench

Parity-generating UART transmitter that serializes one DBIT-wide word per frame: start bit, LSB-first data, optional even/odd parity bit, then stop bit(s). It sits on the transmit side of the UART, fed by the TX FIFO (`tx_start` = FIFO not empty, `tx_done_tick` = FIFO read). It shares the 16x oversampling `s_tick` from the baud-rate generator. Its frames are the counterpart of the parity-checking receiver, so both ends of a link use the same frame format.

---
 rtl/uart_tx_parity_if.sv | 36 +++
 rtl/uart_tx_parity.sv | 157 +++++++++++++++
 tb/tb_uart_tx_parity.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_parity_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_parity_if
// Brief    : Handshake/serial bundle between the TX FIFO side (master) and
//            the parity-generating UART transmitter (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_parity_if #(
    parameter int DBIT = 8
);
    logic            s_tick;
    logic            tx_start;
    logic [DBIT-1:0] din;
    logic            tx_done_tick;
    logic            busy;
    logic            tx;

    modport master (
        output s_tick,
        output tx_start,
        output din,
        input  tx_done_tick,
        input  busy,
        input  tx
    );

    modport slave (
        input  s_tick,
        input  tx_start,
        input  din,
        output tx_done_tick,
        output busy,
        output tx
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_parity.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_parity
// Brief    : UART transmitter with optional even/odd parity. Sends start bit,
//            DBIT data bits LSB first, optional parity bit and SB_TICK ticks
//            of stop, all timed by a 16x oversampling s_tick enable.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_parity #(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            reset,
    uart_tx_parity_if.slave bus
);

    localparam int              c_nw      = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [c_nw-1:0] c_n_last  = c_nw'(DBIT - 1);
    localparam logic [4:0]      c_s_last  = 5'(SB_TICK - 1);
    localparam logic [4:0]      c_bit_end = 5'd15;
    localparam logic            c_odd     = (PARITY_ODD != 0);
    localparam bit              c_par_en  = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t            r_state, w_state_next;
    logic [4:0]        r_s,     w_s_next;
    logic [c_nw-1:0]   r_n,     w_n_next;
    logic [DBIT-1:0]   r_b,     w_b_next;
    logic              r_p,     w_p_next;
    logic              r_tx,    w_tx_next;
    logic              w_done;

    // Frame sequencer: next state, counters, shifter and next line level
    always_comb begin
        w_state_next = r_state;
        w_s_next     = r_s;
        w_n_next     = r_n;
        w_b_next     = r_b;
        w_p_next     = r_p;
        w_tx_next    = r_tx;
        w_done       = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_tx_next = 1'b1;
                if (bus.tx_start) begin
                    // Parity is fixed at capture so later din changes cannot disturb it
                    w_b_next     = bus.din;
                    w_p_next     = (^bus.din) ^ c_odd;
                    w_s_next     = 5'd0;
                    w_state_next = S_START;
                    w_tx_next    = 1'b0;
                end
            end

            S_START: begin
                if (bus.s_tick) begin
                    if (r_s == c_bit_end) begin
                        w_s_next     = 5'd0;
                        w_n_next     = '0;
                        w_state_next = S_DATA;
                        w_tx_next    = r_b[0];
                    end else begin
                        w_s_next = r_s + 5'd1;
                    end
                end
            end

            S_DATA: begin
                if (bus.s_tick) begin
                    if (r_s == c_bit_end) begin
                        w_b_next = r_b >> 1;
                        w_s_next = 5'd0;
                        if (r_n == c_n_last) begin
                            if (c_par_en) begin
                                w_state_next = S_PARITY;
                                w_tx_next    = r_p;
                            end else begin
                                w_state_next = S_STOP;
                                w_tx_next    = 1'b1;
                            end
                        end else begin
                            w_n_next  = r_n + 1'b1;
                            // r_b[1] becomes the LSB once this shift lands
                            w_tx_next = r_b[1];
                        end
                    end else begin
                        w_s_next = r_s + 5'd1;
                    end
                end
            end

            S_PARITY: begin
                if (bus.s_tick) begin
                    if (r_s == c_bit_end) begin
                        w_s_next     = 5'd0;
                        w_state_next = S_STOP;
                        w_tx_next    = 1'b1;
                    end else begin
                        w_s_next = r_s + 5'd1;
                    end
                end
            end

            S_STOP: begin
                if (bus.s_tick) begin
                    if (r_s == c_s_last) begin
                        w_done       = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_s_next = r_s + 5'd1;
                    end
                end
            end

            default: begin
                w_state_next = S_IDLE;
                w_tx_next    = 1'b1;
            end
        endcase
    end

    // State and datapath registers; reset drives the line high immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_s     <= 5'd0;
            r_n     <= '0;
            r_b     <= '0;
            r_p     <= 1'b0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_s     <= w_s_next;
            r_n     <= w_n_next;
            r_b     <= w_b_next;
            r_p     <= w_p_next;
            r_tx    <= w_tx_next;
        end
    end

    assign bus.tx           = r_tx;
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.tx_done_tick = w_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_parity.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_parity
// Brief    : Directed bench for uart_tx_parity. Four instances share one
//            stimulus: default, odd parity, no parity, and SB_TICK = 32.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_parity;

    logic       clk;
    logic       reset;
    logic       s_tick;
    logic       tx_start;
    logic [7:0] din;
    int         tick_period;
    int         tick_cnt;

    int checks;
    int errors;

    uart_tx_parity_if #(.DBIT(8)) if0 ();
    uart_tx_parity_if #(.DBIT(8)) if1 ();
    uart_tx_parity_if #(.DBIT(8)) if2 ();
    uart_tx_parity_if #(.DBIT(8)) if3 ();

    assign if0.s_tick = s_tick;  assign if0.tx_start = tx_start;  assign if0.din = din;
    assign if1.s_tick = s_tick;  assign if1.tx_start = tx_start;  assign if1.din = din;
    assign if2.s_tick = s_tick;  assign if2.tx_start = tx_start;  assign if2.din = din;
    assign if3.s_tick = s_tick;  assign if3.tx_start = tx_start;  assign if3.din = din;

    uart_tx_parity #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0))
        dut0 (.clk(clk), .reset(reset), .bus(if0));
    uart_tx_parity #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(1))
        dut1 (.clk(clk), .reset(reset), .bus(if1));
    uart_tx_parity #(.DBIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0))
        dut2 (.clk(clk), .reset(reset), .bus(if2));
    uart_tx_parity #(.DBIT(8), .SB_TICK(32), .PARITY_EN(1), .PARITY_ODD(0))
        dut3 (.clk(clk), .reset(reset), .bus(if3));

    logic [3:0] w_tx_all, w_busy_all, w_done_all;
    assign w_tx_all   = {if3.tx, if2.tx, if1.tx, if0.tx};
    assign w_busy_all = {if3.busy, if2.busy, if1.busy, if0.busy};
    assign w_done_all = {if3.tx_done_tick, if2.tx_done_tick, if1.tx_done_tick, if0.tx_done_tick};

    // Per-sample record; sample j is taken after the j-th clock edge past the start edge
    logic [3:0] cap_tx   [0:999];
    logic [3:0] cap_busy [0:999];
    logic [3:0] cap_done [0:999];
    logic       cap_tick [0:999];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Baud tick source: one pulse every tick_period clocks
    always @(negedge clk) begin
        if (tick_cnt >= tick_period - 1) begin
            tick_cnt = 0;
            s_tick   = 1'b1;
        end else begin
            tick_cnt = tick_cnt + 1;
            s_tick   = 1'b0;
        end
    end

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk); #1;
        while (w_busy_all !== 4'b0000 && k < 2000) begin
            @(negedge clk); #1;
            k++;
        end
        checks++;
        if (w_busy_all !== 4'b0000) begin
            errors++;
            $display("FAIL wait_idle busy=%b want 0000", w_busy_all);
        end
    endtask

    task automatic start_frame(input logic [7:0] d);
        @(negedge clk);
        din      = d;
        tx_start = 1'b1;
    endtask

    task automatic capture(input int n, input int pulse_at, input logic [7:0] pulse_din,
                           input int release_at, input bit swap, input logic [7:0] swap_din);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            if (j == release_at) tx_start = 1'b0;
            if (j == pulse_at) begin
                tx_start = 1'b1;
                din      = pulse_din;
            end
            if (pulse_at >= 0 && j == pulse_at + 1) tx_start = 1'b0;
            #1;
            cap_tx[j]   = w_tx_all;
            cap_busy[j] = w_busy_all;
            cap_done[j] = w_done_all;
            cap_tick[j] = s_tick;
            if (swap && w_done_all[0]) din = swap_din;
        end
    endtask

    // Expected line level after t consumed ticks of a frame with 'slots' 16-tick bits
    function automatic logic model_tx(input logic [10:0] frame, input int slots, input int t);
        if (t < 16 * slots) return frame[t / 16];
        return 1'b1;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (w_tx_all !== 4'hF) begin errors++; $display("FAIL reset_tx got %b want 1111", w_tx_all); end
        checks++;
        if (w_busy_all !== 4'h0) begin errors++; $display("FAIL reset_busy got %b want 0000", w_busy_all); end
        checks++;
        if (w_done_all !== 4'h0) begin errors++; $display("FAIL reset_done got %b want 0000", w_done_all); end
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (w_busy_all !== 4'h0 || w_tx_all !== 4'hF) begin
            errors++;
            $display("FAIL post_reset_idle busy=%b tx=%b want 0000/1111", w_busy_all, w_tx_all);
        end
    endtask

    task automatic test_default_frame();
        logic [10:0] frame;
        int t, fails, busy_cnt, done_cnt, done_at;
        logic exp;
        frame = {1'b1, 1'b0, 8'hA5, 1'b0};   // A5 has four ones -> even parity 0
        tick_period = 1;
        wait_idle();
        start_frame(8'hA5);
        capture(200, -1, 8'h00, 0, 1'b0, 8'h00);
        t = 0; fails = 0; busy_cnt = 0; done_cnt = 0; done_at = -1;
        for (int j = 0; j < 200; j++) begin
            exp = model_tx(frame, 10, t);
            checks++;
            if (cap_tx[j][0] !== exp) begin
                errors++;
                if (fails == 0) $display("FAIL default_tx sample %0d got %b want %b", j, cap_tx[j][0], exp);
                fails++;
            end
            if (cap_busy[j][0]) busy_cnt++;
            if (cap_done[j][0]) begin done_cnt++; done_at = j; end
            t += int'(cap_tick[j]);
        end
        checks++;
        if (busy_cnt !== 176) begin errors++; $display("FAIL default_busy_span got %0d want 176", busy_cnt); end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL default_done_count got %0d want 1", done_cnt); end
        checks++;
        if (done_at !== 175) begin errors++; $display("FAIL default_done_at got %0d want 175", done_at); end
    endtask

    task automatic test_parity();
        logic [10:0] frm [3];
        int slots [3];
        int done_want [3];
        int t, fails, done_at, busy_cnt;
        logic exp;
        frm[0] = {1'b1, 1'b1, 8'h07, 1'b0};  slots[0] = 10;  done_want[0] = 175;  // even: p=1
        frm[1] = {1'b1, 1'b0, 8'h07, 1'b0};  slots[1] = 10;  done_want[1] = 175;  // odd:  p=0
        frm[2] = {2'b11, 8'h07, 1'b0};       slots[2] = 9;   done_want[2] = 159;  // 16*9+16 = 160
        tick_period = 1;
        wait_idle();
        start_frame(8'h07);
        capture(200, -1, 8'h00, 0, 1'b0, 8'h00);
        for (int d = 0; d < 3; d++) begin
            t = 0; fails = 0; done_at = -1; busy_cnt = 0;
            for (int j = 0; j < 200; j++) begin
                exp = model_tx(frm[d], slots[d], t);
                checks++;
                if (cap_tx[j][d] !== exp) begin
                    errors++;
                    if (fails == 0) $display("FAIL parity_tx dut%0d sample %0d got %b want %b", d, j, cap_tx[j][d], exp);
                    fails++;
                end
                if (cap_busy[j][d]) busy_cnt++;
                if (cap_done[j][d]) done_at = j;
                t += int'(cap_tick[j]);
            end
            checks++;
            if (done_at !== done_want[d]) begin
                errors++;
                $display("FAIL parity_done_at dut%0d got %0d want %0d", d, done_at, done_want[d]);
            end
            checks++;
            if (busy_cnt !== done_want[d] + 1) begin
                errors++;
                $display("FAIL parity_busy_span dut%0d got %0d want %0d", d, busy_cnt, done_want[d] + 1);
            end
        end
        checks++;
        if (cap_tx[152][0] !== 1'b1) begin errors++; $display("FAIL even_parity_bit got %b want 1", cap_tx[152][0]); end
        checks++;
        if (cap_tx[152][1] !== 1'b0) begin errors++; $display("FAIL odd_parity_bit got %b want 0", cap_tx[152][1]); end
    endtask

    task automatic test_sparse_ticks();
        logic [10:0] frame;
        int t, fails, j, ones, zeros, done_cnt;
        logic exp;
        frame = {1'b1, 1'b0, 8'h3C, 1'b0};   // 3C has four ones -> even parity 0
        tick_period = 5;
        wait_idle();
        start_frame(8'h3C);
        capture(920, -1, 8'h00, 0, 1'b0, 8'h00);
        t = 0; fails = 0; done_cnt = 0;
        for (int k = 0; k < 920; k++) begin
            exp = model_tx(frame, 10, t);
            checks++;
            if (cap_tx[k][0] !== exp) begin
                errors++;
                if (fails == 0) $display("FAIL sparse_tx sample %0d got %b want %b", k, cap_tx[k][0], exp);
                fails++;
            end
            if (k > 0 && cap_tx[k][0] !== cap_tx[k-1][0]) begin
                checks++;
                if (cap_tick[k-1] !== 1'b1) begin
                    errors++;
                    $display("FAIL sparse_change_without_tick sample %0d got tick %b want 1", k, cap_tick[k-1]);
                end
            end
            if (cap_done[k][0]) done_cnt++;
            t += int'(cap_tick[k]);
        end
        // data bits 2..5 are ones (4 bits), then bit 6, bit 7 and parity are zeros (3 bits)
        j = 0;
        while (j < 920 && cap_tx[j][0] === 1'b0) j++;
        ones = 0;
        while (j < 920 && cap_tx[j][0] === 1'b1) begin ones++; j++; end
        zeros = 0;
        while (j < 920 && cap_tx[j][0] === 1'b0) begin zeros++; j++; end
        checks++;
        if (ones !== 320) begin errors++; $display("FAIL sparse_ones_run got %0d want 320", ones); end
        checks++;
        if (zeros !== 240) begin errors++; $display("FAIL sparse_zeros_run got %0d want 240", zeros); end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL sparse_done_count got %0d want 1", done_cnt); end
        tick_period = 1;
    endtask

    task automatic test_back_to_back();
        logic [10:0] f1, f2;
        int fails, done_cnt, done_a, done_b;
        logic exp_tx, exp_busy;
        f1 = {1'b1, 1'b0, 8'h55, 1'b0};   // 55: four ones -> p=0
        f2 = {1'b1, 1'b0, 8'hAA, 1'b0};   // AA: four ones -> p=0
        tick_period = 1;
        wait_idle();
        start_frame(8'h55);
        capture(380, -1, 8'h00, 200, 1'b1, 8'hAA);
        fails = 0; done_cnt = 0; done_a = -1; done_b = -1;
        for (int j = 0; j < 380; j++) begin
            if (j < 176) begin
                exp_tx = f1[j / 16];  exp_busy = 1'b1;
            end else if (j == 176) begin
                exp_tx = 1'b1;        exp_busy = 1'b0;
            end else if (j < 353) begin
                exp_tx = f2[(j - 177) / 16];  exp_busy = 1'b1;
            end else begin
                exp_tx = 1'b1;        exp_busy = 1'b0;
            end
            checks++;
            if (cap_tx[j][0] !== exp_tx || cap_busy[j][0] !== exp_busy) begin
                errors++;
                if (fails == 0)
                    $display("FAIL b2b sample %0d got tx=%b busy=%b want tx=%b busy=%b",
                             j, cap_tx[j][0], cap_busy[j][0], exp_tx, exp_busy);
                fails++;
            end
            if (cap_done[j][0]) begin
                done_cnt++;
                if (done_a < 0) done_a = j; else done_b = j;
            end
        end
        checks++;
        if (done_cnt !== 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", done_cnt); end
        checks++;
        if (done_a !== 175 || done_b !== 352) begin
            errors++;
            $display("FAIL b2b_done_at got %0d,%0d want 175,352", done_a, done_b);
        end
    endtask

    task automatic test_ignore_busy();
        logic [10:0] frame;
        int t, fails, done_cnt;
        logic exp_tx, exp_busy;
        frame = {1'b1, 1'b0, 8'h00, 1'b0};
        tick_period = 1;
        wait_idle();
        start_frame(8'h00);
        capture(230, 40, 8'hFF, 0, 1'b0, 8'h00);
        t = 0; fails = 0; done_cnt = 0;
        for (int j = 0; j < 230; j++) begin
            exp_tx   = model_tx(frame, 10, t);
            exp_busy = (t < 176);
            checks++;
            if (cap_tx[j][0] !== exp_tx || cap_busy[j][0] !== exp_busy) begin
                errors++;
                if (fails == 0)
                    $display("FAIL ignore sample %0d got tx=%b busy=%b want tx=%b busy=%b",
                             j, cap_tx[j][0], cap_busy[j][0], exp_tx, exp_busy);
                fails++;
            end
            if (cap_done[j][0]) done_cnt++;
            t += int'(cap_tick[j]);
        end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL ignore_done_count got %0d want 1", done_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        logic [10:0] frame;
        int t, fails, done_at;
        logic exp;
        tick_period = 1;
        wait_idle();
        start_frame(8'h00);
        capture(70, -1, 8'h00, 0, 1'b0, 8'h00);
        // sample 69 lies inside data bit 3 (samples 64..79)
        checks++;
        if (cap_tx[69][0] !== 1'b0 || cap_busy[69][0] !== 1'b1) begin
            errors++;
            $display("FAIL midframe_pre got tx=%b busy=%b want 0/1", cap_tx[69][0], cap_busy[69][0]);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if (w_tx_all !== 4'hF) begin errors++; $display("FAIL async_reset_tx got %b want 1111", w_tx_all); end
        checks++;
        if (w_busy_all !== 4'h0) begin errors++; $display("FAIL async_reset_busy got %b want 0000", w_busy_all); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            checks++;
            if (w_done_all !== 4'h0) begin errors++; $display("FAIL reset_done_tick got %b want 0000", w_done_all); end
        end
        @(negedge clk);
        reset = 1'b1;
        frame = {1'b1, 1'b0, 8'h81, 1'b0};   // 81: two ones -> p=0
        wait_idle();
        start_frame(8'h81);
        capture(200, -1, 8'h00, 0, 1'b0, 8'h00);
        t = 0; fails = 0; done_at = -1;
        for (int j = 0; j < 200; j++) begin
            exp = model_tx(frame, 10, t);
            checks++;
            if (cap_tx[j][0] !== exp) begin
                errors++;
                if (fails == 0) $display("FAIL after_reset_tx sample %0d got %b want %b", j, cap_tx[j][0], exp);
                fails++;
            end
            if (cap_done[j][0]) done_at = j;
            t += int'(cap_tick[j]);
        end
        checks++;
        if (done_at !== 175) begin errors++; $display("FAIL after_reset_done_at got %0d want 175", done_at); end
    endtask

    task automatic test_sb32();
        logic [10:0] frame;
        int t, fails, busy_cnt, done_cnt, done_at;
        logic exp;
        frame = {1'b1, 1'b0, 8'hC3, 1'b0};   // C3: four ones -> p=0
        tick_period = 1;
        wait_idle();
        start_frame(8'hC3);
        capture(220, -1, 8'h00, 0, 1'b0, 8'h00);
        t = 0; fails = 0; busy_cnt = 0; done_cnt = 0; done_at = -1;
        for (int j = 0; j < 220; j++) begin
            exp = model_tx(frame, 10, t);
            checks++;
            if (cap_tx[j][3] !== exp) begin
                errors++;
                if (fails == 0) $display("FAIL sb32_tx sample %0d got %b want %b", j, cap_tx[j][3], exp);
                fails++;
            end
            if (cap_busy[j][3]) busy_cnt++;
            if (cap_done[j][3]) begin done_cnt++; done_at = j; end
            t += int'(cap_tick[j]);
        end
        checks++;
        if (done_cnt !== 1 || done_at !== 191) begin
            errors++;
            $display("FAIL sb32_done got count %0d at %0d want 1 at 191", done_cnt, done_at);
        end
        checks++;
        if (busy_cnt !== 192) begin errors++; $display("FAIL sb32_busy_span got %0d want 192", busy_cnt); end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b0;
        tx_start    = 1'b0;
        din         = 8'h00;
        s_tick      = 1'b0;
        tick_cnt    = 0;
        tick_period = 1;

        test_reset();
        test_default_frame();
        test_parity();
        test_sparse_ticks();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid_frame();
        test_sb32();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
